// File: rtl/ram8.sv
// ram8: eight-word by 16-bit random-access memory for the Hack CPU.
// Each stored bit is a D flip-flop fed by a load mux that recirculates the
// current value. A dmux8way spreads the single load strobe onto eight
// per-word load lines. A mux8way16 drives out from the addressed word.
// Reset is asynchronous and active-low. Every flip-flop resets to its bit of
// RESET_VALUE, so out reads RESET_VALUE for any address while rst_n is low.

// 1-bit storage primitive with asynchronous active-low reset.
module ram8_dff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Capture d on the rising edge; rst_n low forces the reset value immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// One-hot demultiplexer: routes in onto the output line picked by sel.
module ram8_dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);

    // At most one line is active, and only when in is high.
    always_comb begin
        out      = 8'b0;
        out[sel] = in;
    end

endmodule

// Eight-input 16-bit multiplexer selecting one word by sel.
module ram8_mux8way16 (
    input  logic [7:0][15:0] words,
    input  logic [2:0]       sel,
    output logic [15:0]      out
);

    // Purely combinational read path; no registers between sel and out.
    always_comb begin
        out = words[sel];
    end

endmodule

// Top level: 8 x 16 memory assembled from 128 bit cells.
module ram8 #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    output logic [15:0] out
);

    logic [7:0]       word_load;
    logic [7:0][15:0] word_q;
    logic [7:0][15:0] word_d;

    // The write address is whatever address holds at the clock edge, because
    // word_load is decoded combinationally and sampled by the flip-flops.
    ram8_dmux8way u_decode (
        .in  (load),
        .sel (address),
        .out (word_load)
    );

    for (genvar w = 0; w < 8; w++) begin : g_word
        for (genvar b = 0; b < 16; b++) begin : g_bit
            // Bit cell: the load mux recirculates q unless this word is written.
            assign word_d[w][b] = word_load[w] ? in[b] : word_q[w][b];

            ram8_dff #(
                .RST_VAL (RESET_VALUE[b])
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (word_d[w][b]),
                .q     (word_q[w][b])
            );
        end
    end

    // No bypass from in: a same-address write shows up only after the edge.
    ram8_mux8way16 u_read (
        .words (word_q),
        .sel   (address),
        .out   (out)
    );

endmodule
